// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: loadable DIGITS-digit BCD up/down counter with programmable terminal count
module bcd_updown_counter #(
  parameter int DIGITS = 2,
  localparam int W = 4 * DIGITS
) (
  input  logic         clock,
  input  logic         RST,
  input  logic         tick,
  input  logic         up_down,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic [W-1:0] max_value,
  output logic [W-1:0] number,
  output logic         wrap,
  output logic         load_err
);
  logic [W-1:0] inc, dec, tick_num;
  logic         c, b, lv_ok, tick_wrap;
  always_comb begin
    inc = number;
    dec = number;
    c = 1'b1;
    b = 1'b1;
    lv_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      inc[4*i +: 4] = c ? (number[4*i +: 4] == 4'd9 ? 4'd0 : number[4*i +: 4] + 4'd1) : number[4*i +: 4];
      dec[4*i +: 4] = b ? (number[4*i +: 4] == 4'd0 ? 4'd9 : number[4*i +: 4] - 4'd1) : number[4*i +: 4];
      c = c && (number[4*i +: 4] == 4'd9);
      b = b && (number[4*i +: 4] == 4'd0);
      lv_ok = lv_ok && (load_value[4*i +: 4] <= 4'd9);
    end
    lv_ok = lv_ok && (load_value <= max_value);
    tick_num = up_down ? (number >= max_value ? '0 : inc)
                       : ((number == '0 || number > max_value) ? max_value : dec);
    tick_wrap = up_down ? (number >= max_value) : (number == '0);
  end
  always_ff @(posedge clock) begin
    if (RST) begin
      number   <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (clear) number <= '0;
      else if (load) begin
        if (lv_ok) number <= load_value;
        else load_err <= 1'b1;
      end else if (tick) begin
        number <= tick_num;
        wrap   <= tick_wrap;
      end
    end
  end
endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb_bcd_updown_counter: directed self-checking bench for a 2-digit bcd_updown_counter
module tb_bcd_updown_counter;
  logic       clock = 1'b0;
  logic       rst = 1'b1, tick = 1'b0, up_down = 1'b1, clear = 1'b0, load = 1'b0;
  logic [7:0] load_value = '0, max_value = 8'h99;
  logic [7:0] number;
  logic       wrap, load_err;
  int         vectors = 0, errs = 0;

  bcd_updown_counter #(.DIGITS(2)) dut (
    .clock(clock), .RST(rst), .tick(tick), .up_down(up_down), .clear(clear), .load(load),
    .load_value(load_value), .max_value(max_value), .number(number), .wrap(wrap), .load_err(load_err)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] n, input logic w, input logic e);
    vectors++;
    assert (number === n) else begin errs++; $error("FAIL %s number got %h want %h", tag, number, n); end
    assert (wrap === w) else begin errs++; $error("FAIL %s wrap got %b want %b", tag, wrap, w); end
    assert (load_err === e) else begin errs++; $error("FAIL %s load_err got %b want %b", tag, load_err, e); end
  endtask

  initial begin
    step();
    check("reset", 8'h00, 1'b0, 1'b0);
    rst = 1'b0; tick = 1'b1; up_down = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      step();
      check("up99", bcd(i % 100), i == 100, 1'b0);
    end
    tick = 1'b0;
    step();
    check("hold", 8'h00, 1'b0, 1'b0);
    max_value = 8'h59; up_down = 1'b0; tick = 1'b1;
    step();
    check("down_wrap", 8'h59, 1'b1, 1'b0);
    for (int k = 58; k >= 49; k--) begin
      step();
      check("down59", bcd(k), 1'b0, 1'b0);
    end
    tick = 1'b0; load = 1'b1; load_value = 8'h7A;
    step();
    check("load_bad_digit", 8'h49, 1'b0, 1'b1);
    load_value = 8'h65;
    step();
    check("load_over_max", 8'h49, 1'b0, 1'b1);
    load_value = 8'h42;
    step();
    check("load_ok", 8'h42, 1'b0, 1'b0);
    load_value = 8'h59;
    step();
    check("load_eq_max", 8'h59, 1'b0, 1'b0);
    load = 1'b0;
    step();
    check("hold_after_load", 8'h59, 1'b0, 1'b0);
    clear = 1'b1; load = 1'b1; tick = 1'b1; up_down = 1'b1; load_value = 8'h33;
    step();
    check("clear_prio", 8'h00, 1'b0, 1'b0);
    clear = 1'b0;
    step();
    check("load_over_tick", 8'h33, 1'b0, 1'b0);
    load_value = 8'h45; tick = 1'b0;
    step();
    check("load45", 8'h45, 1'b0, 1'b0);
    load = 1'b0; tick = 1'b1; up_down = 1'b1;
    step();
    check("up46", 8'h46, 1'b0, 1'b0);
    max_value = 8'h30;
    step();
    check("up_over_max", 8'h00, 1'b1, 1'b0);
    max_value = 8'h59; tick = 1'b0; load = 1'b1; load_value = 8'h45;
    step();
    check("reload45", 8'h45, 1'b0, 1'b0);
    load = 1'b0; max_value = 8'h30; tick = 1'b1; up_down = 1'b0;
    step();
    check("down_over_max", 8'h30, 1'b0, 1'b0);
    step();
    check("down29", 8'h29, 1'b0, 1'b0);
    max_value = 8'h00; up_down = 1'b1;
    step();
    check("max0_up_a", 8'h00, 1'b1, 1'b0);
    step();
    check("max0_up_b", 8'h00, 1'b1, 1'b0);
    up_down = 1'b0;
    step();
    check("max0_down", 8'h00, 1'b1, 1'b0);
    max_value = 8'h99; tick = 1'b0; load = 1'b1; load_value = 8'h99;
    step();
    check("load99", 8'h99, 1'b0, 1'b0);
    load = 1'b0; up_down = 1'b1; tick = 1'b1; rst = 1'b1;
    step();
    check("rst_over_wrap", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    check("after_rst", 8'h01, 1'b0, 1'b0);
    tick = 1'b0;
    step();
    check("final_hold", 8'h01, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 Parameter DIGITS SHALL default to 2, legal range 1..8, and set the number of BCD digits (datapath width W = 4*DIGITS).
REQ-002 Port clock, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port RST, input, 1: reset, synchronous and active-high.
REQ-004 Port tick, input, 1: count enable, sampled each rising edge.
REQ-005 Port up_down, input, 1: direction; 1 = count up, 0 = count down.
REQ-006 Port clear, input, 1: synchronous clear to zero.
REQ-007 Port load, input, 1: synchronous load request.
REQ-008 Port load_value, input, W: BCD value to load.
REQ-009 Port max_value, input, W: BCD terminal count; the driver SHALL keep it valid BCD; behaviour with invalid max_value is unspecified.
REQ-010 Port number, output, W: current BCD count, registered; digit 0 in bits [3:0].
REQ-011 Port wrap, output, 1: registered one-cycle pulse marking a wrap.
REQ-012 Port load_err, output, 1: registered one-cycle pulse marking a rejected load.

Function
REQ-013 Per edge, priority SHALL be RST > clear > load > tick; lower-priority requests in the same cycle SHALL be discarded, not deferred.
REQ-014 clear SHALL set number to 0, with wrap = 0 and load_err = 0 in the following cycle.
REQ-015 A load SHALL be accepted only if every digit of load_value is <= 9 and load_value <= max_value (BCD compare); accepted loads set number = load_value.
REQ-016 A rejected load SHALL leave number unchanged and pulse load_err = 1 for exactly the following cycle.
REQ-017 Up tick with number < max_value: BCD increment; a digit at 9 becomes 0 and carries into the next digit, rippling across all DIGITS in one cycle.
REQ-018 Up tick with number >= max_value: number becomes 0 and wrap pulses.
REQ-019 Down tick with number == 0: number becomes max_value and wrap pulses.
REQ-020 Down tick with 0 < number <= max_value: BCD decrement; a digit at 0 becomes 9 and borrows from the next digit.
REQ-021 Down tick with number > max_value (max_value lowered at run time): number becomes max_value, no wrap.
REQ-022 With tick = 0 and no clear or load, number SHALL hold.
REQ-023 wrap and load_err SHALL be 0 in every cycle not named in REQ-016/018/019, and SHALL never both be 1.
REQ-024 Latency: every change of number, wrap, or load_err SHALL appear exactly one clock after the sampling edge; there is no combinational path from any input to any output.
REQ-025 max_value = 0 SHALL be legal: every tick (either direction) keeps number at 0 and pulses wrap.
REQ-026 number SHALL always hold valid BCD (every digit <= 9) and SHALL be <= max_value whenever max_value is unchanged since the last clear, load, or reset.

Reset
REQ-027 RST = 1 at a rising edge SHALL force number = 0, wrap = 0, load_err = 0, overriding clear, load, and tick.
REQ-028 Reset asserted mid-count or during a wrap cycle SHALL discard the pending update; counting resumes from 0 on the first edge with RST = 0.
REQ-029 There SHALL be no asynchronous reset path; outputs are undefined only before the first edge with RST = 1.

Verification (DIGITS = 2)
REQ-030 max_value = 99, up_down = 1, tick held for 100 cycles from reset -> number steps 00..99 with digit carry at 09->10, then 00; wrap = 1 only in the cycle number returns to 00.
REQ-031 max_value = 59, up_down = 0, tick from 00 -> number = 59, wrap = 1, then 58, 57, ...; 50 -> 49 borrow correct.
REQ-032 max_value = 59, load with load_value = 0x7A (invalid digit), then 0x65 (> max) -> number unchanged, load_err pulses twice; load 0x42 -> number = 42, load_err = 0.
REQ-033 Same edge with clear = 1, load = 1, tick = 1 -> number = 00; with load = 1, tick = 1 only -> number = load_value, no increment.
REQ-034 number = 45 counting up, max_value lowered to 30 -> next up tick gives 00 with wrap; separate run, next down tick gives 30 with no wrap.
REQ-035 RST = 1 in the same cycle as a wrapping tick at number = 99 -> number = 00, wrap = 0; after release, first tick gives 01.
